// File: rtl/toggle_pkg.sv
// Shared constants and helpers for toggle-encoded event receivers.
package toggle_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 4;
    localparam int TOTAL_W_DEF     = 8;

    // Largest count a pending counter of the given width can hold.
    function automatic int max_pending(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/toggle_event_decoder_sync_chain.sv
// Multi-stage synchroniser for a single asynchronous level signal.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] s;

    // s[0] samples the asynchronous input; higher stages resolve metastability.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s <= '0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], d};
        end
    end

    assign q = s[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes a toggle-encoded event wire into buffered events behind valid/ready.
module toggle_event_decoder
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TOTAL_W     = TOTAL_W_DEF
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               t_in,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [CNT_W-1:0]   pending,
    output logic [TOTAL_W-1:0] total,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic               ack_t
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(max_pending(CNT_W));

    logic s_last;
    logic prev;
    logic ev_edge;
    logic pop;
    logic drop;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .clear_n(clear_n),
        .d      (t_in),
        .q      (s_last)
    );

    assign ev_edge  = s_last ^ prev;
    assign ev_valid = (pending != '0);
    assign pop      = ev_valid && ev_ready;
    // A simultaneous pop frees a slot, so only a non-popping full buffer drops.
    assign drop     = ev_edge && !pop && (pending == PEND_MAX);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            prev     <= 1'b0;
            pending  <= '0;
            total    <= '0;
            overflow <= 1'b0;
            ack_t    <= 1'b0;
        end else begin
            prev <= s_last;
            if (ev_edge) begin
                ack_t <= ~ack_t;
            end
            // Set wins over clear so a drop is never lost.
            overflow <= drop | (overflow & ~ovf_clr);
            if (ev_edge && pop) begin
                total <= total + TOTAL_W'(1);
            end else if (ev_edge && !drop) begin
                pending <= pending + CNT_W'(1);
                total   <= total + TOTAL_W'(1);
            end else if (!ev_edge && pop) begin
                pending <= pending - CNT_W'(1);
            end
        end
    end

endmodule
